// File: rtl/psl_command_responder.sv
// PSL-side command/buffer/response responder standing in for the real PSL.
// Queues AFU commands, serves read_cl_na / write_na against an external line memory.
//
// state  | meaning
// IDLE   | wait for a queued command, pop it
// CHECK  | parity / opcode / address checks, latch response code
// RD0    | read even half-line from memory
// RD1    | read odd half-line, buffer-write even half
// BW1    | buffer-write odd half
// BR0    | buffer-read request for even half
// BR1    | buffer-read request for odd half
// WAITW  | wait until the odd half has been written to memory
// RSP    | issue response, return one credit
module psl_command_responder #(
  parameter int          CMD_DEPTH  = 4,
  parameter int          MEM_LINES  = 1024,
  parameter logic [63:0] BASE_ADDR  = 64'h0,
  parameter int          BR_LATENCY = 1,
  localparam int         AW         = $clog2(2 * MEM_LINES)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cmd_valid,
  input  logic [12:0]   cmd_code,
  input  logic          cmd_code_parity,
  input  logic [7:0]    cmd_tag,
  input  logic          cmd_tag_parity,
  input  logic [0:63]   cmd_address,
  input  logic          cmd_address_parity,
  input  logic [11:0]   cmd_size,
  output logic [7:0]    croom,
  output logic          bw_valid,
  output logic [7:0]    bw_tag,
  output logic          bw_tag_parity,
  output logic [5:0]    bw_ad,
  output logic [511:0]  bw_data,
  output logic [7:0]    bw_parity,
  output logic          br_valid,
  output logic [7:0]    br_tag,
  output logic          br_tag_parity,
  output logic [5:0]    br_ad,
  input  logic [511:0]  br_data,
  output logic          rsp_valid,
  output logic [7:0]    rsp_tag,
  output logic          rsp_tag_parity,
  output logic [7:0]    rsp_code,
  output logic [8:0]    rsp_credits,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [511:0]  mem_wdata,
  input  logic [511:0]  mem_rdata,
  output logic          overflow_err
);

  localparam logic [12:0] CODE_READ  = 13'h0A00;
  localparam logic [12:0] CODE_WRITE = 13'h0D00;
  localparam logic [7:0]  RSP_DONE   = 8'h00;
  localparam logic [7:0]  RSP_AERROR = 8'h01;
  localparam logic [7:0]  RSP_FAILED = 8'h08;
  localparam int EW = 100;
  localparam int PW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CW = $clog2(CMD_DEPTH + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_RD0, S_RD1, S_BW1, S_BR0, S_BR1, S_WAITW, S_RSP
  } state_t;

  state_t state, state_next;

  // ---------------- command FIFO ----------------
  logic [EW-1:0] fifo_mem [CMD_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop;
  logic [EW-1:0] cmd_entry;

  assign cmd_entry = {cmd_code, cmd_code_parity, cmd_tag, cmd_tag_parity,
                      cmd_address, cmd_address_parity, cmd_size};
  assign full  = (count == CW'(CMD_DEPTH));
  assign empty = (count == '0);
  assign pop   = (state == S_IDLE) && !empty;
  assign push  = cmd_valid && (!full || pop);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(CMD_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= cmd_entry;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (cmd_valid && !push) overflow_err <= 1'b1;
    end
  end

  // ---------------- current command ----------------
  logic [EW-1:0] cur_entry;
  logic [12:0]   cur_code;
  logic          cur_code_par, cur_tag_par, cur_addr_par;
  logic [7:0]    cur_tag;
  logic [63:0]   cur_addr;
  logic [11:0]   cur_size;

  always_ff @(posedge clock) begin
    if (pop) cur_entry <= fifo_mem[rd_ptr];
  end

  assign cur_code     = cur_entry[99:87];
  assign cur_code_par = cur_entry[86];
  assign cur_tag      = cur_entry[85:78];
  assign cur_tag_par  = cur_entry[77];
  assign cur_addr     = cur_entry[76:13];
  assign cur_addr_par = cur_entry[12];
  assign cur_size     = cur_entry[11:0];

  logic          parity_bad, code_bad, size_bad, align_bad, range_bad, addr_bad, is_write;
  logic [11:0]   size_m1;
  logic [63:0]   offset, line;
  logic [AW-1:0] word_base;

  assign parity_bad = (cur_code_par != ~^cur_code) || (cur_tag_par != ~^cur_tag) ||
                      (cur_addr_par != ~^cur_addr);
  assign code_bad   = (cur_code != CODE_READ) && (cur_code != CODE_WRITE);
  assign size_m1    = cur_size - 12'd1;
  assign size_bad   = (cur_size == 12'd0) || (cur_size > 12'd128) || ((cur_size & size_m1) != 12'd0);
  assign align_bad  = (cur_addr & {52'b0, size_m1}) != 64'd0;
  assign offset     = cur_addr - BASE_ADDR;
  assign line       = offset >> 7;
  assign range_bad  = (cur_addr < BASE_ADDR) || (line >= 64'(MEM_LINES));
  assign addr_bad   = size_bad || align_bad || range_bad;
  assign is_write   = (cur_code == CODE_WRITE);
  assign word_base  = {line[AW-2:0], 1'b0};

  always_ff @(posedge clock) begin
    if (reset)                  rsp_code <= RSP_DONE;
    else if (state == S_CHECK)  rsp_code <= (parity_bad || code_bad) ? RSP_FAILED :
                                            addr_bad ? RSP_AERROR : RSP_DONE;
  end

  // ---------------- buffer-read return tracking ----------------
  logic [BR_LATENCY-1:0] sr_valid, sr_ad;
  logic                  wr_fire, wr_ad;

  always_ff @(posedge clock) begin
    if (reset) begin
      sr_valid <= '0;
      sr_ad    <= '0;
    end else begin
      sr_valid[0] <= br_valid;
      sr_ad[0]    <= br_ad[0];
      for (int i = 1; i < BR_LATENCY; i++) begin
        sr_valid[i] <= sr_valid[i-1];
        sr_ad[i]    <= sr_ad[i-1];
      end
    end
  end

  assign wr_fire = sr_valid[BR_LATENCY-1];
  assign wr_ad   = sr_ad[BR_LATENCY-1];

  // ---------------- FSM ----------------
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    bw_valid   = 1'b0;
    bw_ad      = 6'd0;
    br_valid   = 1'b0;
    br_ad      = 6'd0;
    rsp_valid  = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = word_base;
    case (state)
      S_IDLE:  if (!empty) state_next = S_CHECK;
      S_CHECK: begin
        if (parity_bad || code_bad || addr_bad) state_next = S_RSP;
        else if (is_write)                      state_next = S_BR0;
        else                                    state_next = S_RD0;
      end
      S_RD0: begin
        mem_en     = 1'b1;
        state_next = S_RD1;
      end
      S_RD1: begin
        mem_en     = 1'b1;
        mem_addr   = word_base | AW'(1);
        bw_valid   = 1'b1;
        state_next = S_BW1;
      end
      S_BW1: begin
        bw_valid   = 1'b1;
        bw_ad      = 6'd1;
        state_next = S_RSP;
      end
      S_BR0: begin
        br_valid   = 1'b1;
        state_next = S_BR1;
      end
      S_BR1: begin
        br_valid   = 1'b1;
        br_ad      = 6'd1;
        state_next = S_WAITW;
      end
      S_WAITW: if (wr_fire && wr_ad) state_next = S_RSP;
      S_RSP: begin
        rsp_valid  = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    // returning buffer-read data lands in memory independent of the FSM state
    if (wr_fire) begin
      mem_en   = 1'b1;
      mem_we   = 1'b1;
      mem_addr = word_base | AW'(wr_ad);
    end
  end

  // ---------------- output formatting ----------------
  assign croom          = 8'(CMD_DEPTH);
  assign bw_data        = mem_rdata;
  assign mem_wdata      = br_data;
  assign bw_tag         = cur_tag;
  assign br_tag         = cur_tag;
  assign rsp_tag        = cur_tag;
  assign bw_tag_parity  = ~^cur_tag;
  assign br_tag_parity  = ~^cur_tag;
  assign rsp_tag_parity = ~^cur_tag;
  assign rsp_credits    = {8'd0, rsp_valid};

  always_comb begin
    bw_parity = '0;
    for (int i = 0; i < 8; i++) bw_parity[i] = ~^bw_data[64*i +: 64];
  end

endmodule

// File: tb/tb_psl_command_responder.sv
// Directed self-checking bench for psl_command_responder with a behavioural
// line memory and an AFU buffer-read model of latency 3.
module tb_psl_command_responder;

  localparam int MEM_LINES = 16;
  localparam int AW = $clog2(2 * MEM_LINES);
  localparam logic [511:0] DAT_A = {8{64'h0000_0000_0000_0001}};
  localparam logic [511:0] DAT_B = {8{64'h0000_0000_0000_0003}};
  localparam logic [511:0] DAT_C = {16{32'hC0DE_0001}};
  localparam logic [511:0] DAT_D = {16{32'hD00D_0002}};

  logic          clock = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic [12:0]   cmd_code;
  logic          cmd_code_parity;
  logic [7:0]    cmd_tag;
  logic          cmd_tag_parity;
  logic [0:63]   cmd_address;
  logic          cmd_address_parity;
  logic [11:0]   cmd_size;
  logic [7:0]    croom;
  logic          bw_valid, bw_tag_parity, br_valid, br_tag_parity, rsp_valid, rsp_tag_parity;
  logic [7:0]    bw_tag, br_tag, rsp_tag, rsp_code, bw_parity;
  logic [5:0]    bw_ad, br_ad;
  logic [511:0]  bw_data, br_data, mem_wdata;
  logic [511:0]  mem_rdata;
  logic [8:0]    rsp_credits;
  logic          mem_en, mem_we, overflow_err;
  logic [AW-1:0] mem_addr;

  psl_command_responder #(
    .CMD_DEPTH(4), .MEM_LINES(MEM_LINES), .BASE_ADDR(64'h0), .BR_LATENCY(3)
  ) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_code_parity(cmd_code_parity),
    .cmd_tag(cmd_tag), .cmd_tag_parity(cmd_tag_parity), .cmd_address(cmd_address),
    .cmd_address_parity(cmd_address_parity), .cmd_size(cmd_size), .croom(croom),
    .bw_valid(bw_valid), .bw_tag(bw_tag), .bw_tag_parity(bw_tag_parity), .bw_ad(bw_ad),
    .bw_data(bw_data), .bw_parity(bw_parity),
    .br_valid(br_valid), .br_tag(br_tag), .br_tag_parity(br_tag_parity), .br_ad(br_ad),
    .br_data(br_data),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_tag_parity(rsp_tag_parity),
    .rsp_code(rsp_code), .rsp_credits(rsp_credits),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .overflow_err(overflow_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // line memory with a bench-side preload port
  logic [511:0]  mem [0:2*MEM_LINES-1];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [511:0]  pl_data = '0;
  always @(posedge clock) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
  end

  // AFU answers each br_valid with C (ad 0) or D (ad 1) three cycles later
  logic [2:0] brq_v = '0, brq_ad = '0;
  always @(posedge clock) begin
    brq_v  <= {brq_v[1:0], br_valid};
    brq_ad <= {brq_ad[1:0], br_ad[0]};
  end
  assign br_data = brq_v[2] ? (brq_ad[2] ? DAT_D : DAT_C) : '0;

  typedef struct { int cyc; logic [5:0] ad; logic [7:0] tag; logic tpar; logic [511:0] data; logic [7:0] par; } bw_ev_t;
  typedef struct { int cyc; logic [5:0] ad; logic [7:0] tag; } br_ev_t;
  typedef struct { int cyc; logic [7:0] tag; logic tpar; logic [7:0] code; logic [8:0] cred; } rsp_ev_t;
  bw_ev_t  bw_q[$];
  br_ev_t  br_q[$];
  rsp_ev_t rsp_q[$];

  always @(negedge clock) begin
    if (bw_valid)  bw_q.push_back('{cyc, bw_ad, bw_tag, bw_tag_parity, bw_data, bw_parity});
    if (br_valid)  br_q.push_back('{cyc, br_ad, br_tag});
    if (rsp_valid) rsp_q.push_back('{cyc, rsp_tag, rsp_tag_parity, rsp_code, rsp_credits});
  end

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input logic [12:0] code, input logic [7:0] tag, input logic [63:0] addr,
                          input logic [11:0] size, input bit bad_par, output int at);
    at                 = cyc;
    cmd_valid          = 1'b1;
    cmd_code           = code;
    cmd_code_parity    = ~^code;
    cmd_tag            = tag;
    cmd_tag_parity     = ~^tag;
    cmd_address        = addr;
    cmd_address_parity = (~^addr) ^ bad_par;
    cmd_size           = size;
    @(negedge clock);
  endtask

  task automatic cmd_idle();
    cmd_valid = 1'b0;
  endtask

  task automatic preload(input int a, input logic [511:0] d);
    pl_en   = 1'b1;
    pl_addr = AW'(a);
    pl_data = d;
    @(negedge clock);
    pl_en = 1'b0;
  endtask

  task automatic clear_q();
    bw_q.delete();
    br_q.delete();
    rsp_q.delete();
  endtask

  typedef struct { logic [12:0] code; logic [63:0] addr; logic [11:0] size; bit bad; logic [7:0] exp_code; int lat; } err_vec_t;
  err_vec_t evec[5] = '{
    '{13'h0A00, 64'h0,   12'd32,  1'b1, 8'h08, 3},  // address parity flipped
    '{13'h0A00, 64'h800, 12'd128, 1'b0, 8'h01, 3},  // line index = MEM_LINES
    '{13'h0A00, 64'h40,  12'd128, 1'b0, 8'h01, 3},  // misaligned for size
    '{13'h0B00, 64'h0,   12'd128, 1'b0, 8'h08, 3},  // unknown opcode
    '{13'h0A00, 64'h780, 12'd128, 1'b0, 8'h00, 6}   // last valid line
  };

  initial begin
    int n;
    int bcount;
    logic [7:0] exp_tags [5] = '{8'h20, 8'h10, 8'h11, 8'h12, 8'h13};

    reset = 1'b1;
    cmd_valid = 1'b0; cmd_code = '0; cmd_code_parity = 1'b0; cmd_tag = '0; cmd_tag_parity = 1'b0;
    cmd_address = '0; cmd_address_parity = 1'b0; cmd_size = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    check_val("rst_croom", croom, 8'd4);
    check_val("rst_valids", {bw_valid, br_valid, rsp_valid, mem_en, mem_we}, 5'b0);
    check_val("rst_credits", rsp_credits, 9'd0);
    check_val("rst_overflow", overflow_err, 1'b0);

    // read line 0
    preload(0, DAT_A);
    preload(1, DAT_B);
    clear_q();
    send_cmd(13'h0A00, 8'hFF, 64'h0, 12'd32, 1'b0, n);
    cmd_idle();
    repeat (12) @(negedge clock);
    check_val("rd_bw_count", bw_q.size(), 2);
    if (bw_q.size() == 2) begin
      check_val("rd_bw0_cyc", bw_q[0].cyc, n + 4);
      check_val("rd_bw0_ad", bw_q[0].ad, 6'd0);
      check_val("rd_bw0_data", bw_q[0].data, DAT_A);
      check_val("rd_bw0_par", bw_q[0].par, 8'h00);
      check_val("rd_bw0_tag", {bw_q[0].tag, bw_q[0].tpar}, {8'hFF, 1'b1});
      check_val("rd_bw1_cyc", bw_q[1].cyc, n + 5);
      check_val("rd_bw1_ad", bw_q[1].ad, 6'd1);
      check_val("rd_bw1_data", bw_q[1].data, DAT_B);
      check_val("rd_bw1_par", bw_q[1].par, 8'hFF);
    end
    check_val("rd_rsp_count", rsp_q.size(), 1);
    if (rsp_q.size() == 1) begin
      check_val("rd_rsp_cyc", rsp_q[0].cyc, n + 6);
      check_val("rd_rsp", {rsp_q[0].tag, rsp_q[0].tpar, rsp_q[0].code, rsp_q[0].cred},
                {8'hFF, 1'b1, 8'h00, 9'd1});
    end

    // write line 1 via buffer-read
    clear_q();
    send_cmd(13'h0D00, 8'h05, 64'h80, 12'd128, 1'b0, n);
    cmd_idle();
    repeat (15) @(negedge clock);
    check_val("wr_br_count", br_q.size(), 2);
    if (br_q.size() == 2) begin
      check_val("wr_br0", {br_q[0].cyc, br_q[0].ad, br_q[0].tag}, {n + 3, 6'd0, 8'h05});
      check_val("wr_br1", {br_q[1].cyc, br_q[1].ad, br_q[1].tag}, {n + 4, 6'd1, 8'h05});
    end
    check_val("wr_mem2", mem[2], DAT_C);
    check_val("wr_mem3", mem[3], DAT_D);
    check_val("wr_bw_none", bw_q.size(), 0);
    check_val("wr_rsp_count", rsp_q.size(), 1);
    if (rsp_q.size() == 1)
      check_val("wr_rsp", {rsp_q[0].cyc, rsp_q[0].tag, rsp_q[0].tpar, rsp_q[0].code, rsp_q[0].cred},
                {n + 8, 8'h05, 1'b1, 8'h00, 9'd1});

    // error and boundary table
    for (int i = 0; i < 5; i++) begin
      clear_q();
      send_cmd(evec[i].code, 8'h60 + 8'(i), evec[i].addr, evec[i].size, evec[i].bad, n);
      cmd_idle();
      repeat (10) @(negedge clock);
      check_val($sformatf("err%0d_rsp_count", i), rsp_q.size(), 1);
      if (rsp_q.size() == 1)
        check_val($sformatf("err%0d_rsp", i), {rsp_q[0].cyc, rsp_q[0].tag, rsp_q[0].code},
                  {n + evec[i].lat, 8'h60 + 8'(i), evec[i].exp_code});
      check_val($sformatf("err%0d_bw_count", i), bw_q.size(), (evec[i].exp_code == 8'h00) ? 2 : 0);
    end

    // one busy command, then five back-to-back into a 4-deep FIFO
    check_val("ovf_before", overflow_err, 1'b0);
    clear_q();
    send_cmd(13'h0A00, 8'h20, 64'h0, 12'd128, 1'b0, n);
    for (int i = 0; i < 5; i++) send_cmd(13'h0A00, 8'h10 + 8'(i), 64'h0, 12'd128, 1'b0, n);
    cmd_idle();
    repeat (60) @(negedge clock);
    check_val("ovf_rsp_count", rsp_q.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < rsp_q.size()) check_val($sformatf("ovf_rsp%0d_tag", i), rsp_q[i].tag, exp_tags[i]);
    if (rsp_q.size() > 1) check_val("ovf_rsp1_tpar", rsp_q[1].tpar, 1'b0);
    check_val("ovf_sticky", overflow_err, 1'b1);

    // reset during BW1 with two commands queued
    clear_q();
    send_cmd(13'h0A00, 8'h30, 64'h0, 12'd128, 1'b0, n);
    send_cmd(13'h0A00, 8'h31, 64'h0, 12'd128, 1'b0, bcount);
    send_cmd(13'h0A00, 8'h32, 64'h0, 12'd128, 1'b0, bcount);
    cmd_idle();
    repeat (2) @(negedge clock);
    check_val("rst_mid_bw1", {bw_valid, bw_ad}, {1'b1, 6'd1});
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    bcount = bw_q.size();
    repeat (20) @(negedge clock);
    check_val("rst_mid_no_rsp", rsp_q.size(), 0);
    check_val("rst_mid_no_bw", bw_q.size(), bcount);
    check_val("rst_mid_ovf_clr", overflow_err, 1'b0);

    clear_q();
    send_cmd(13'h0A00, 8'h40, 64'h80, 12'd64, 1'b0, n);
    cmd_idle();
    repeat (12) @(negedge clock);
    check_val("post_rst_rsp_count", rsp_q.size(), 1);
    if (rsp_q.size() == 1)
      check_val("post_rst_rsp", {rsp_q[0].cyc, rsp_q[0].tag, rsp_q[0].code}, {n + 6, 8'h40, 8'h00});
    check_val("post_rst_bw_count", bw_q.size(), 2);
    if (bw_q.size() == 2) check_val("post_rst_bw0_data", bw_q[0].data, DAT_C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
